// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the seq_gen sequence generator: mode encoding,
// origin values, maximal-length LFSR taps and Gray-code conversions.
package seq_gen_pkg;

    localparam int MAX_WIDTH = 16;

    typedef logic [MAX_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        MODE_BIN_UP   = 3'd0,
        MODE_BIN_DOWN = 3'd1,
        MODE_GRAY     = 3'd2,
        MODE_JOHNSON  = 3'd3,
        MODE_LFSR     = 3'd4
    } seq_mode_t;

    function automatic word_t width_mask(input int w);
        return word_t'((32'd1 << w) - 32'd1);
    endfunction

    function automatic word_t origin_val(input seq_mode_t m, input int w);
        word_t o;
        case (m)
            MODE_BIN_DOWN: o = width_mask(w);
            MODE_LFSR:     o = word_t'(1);
            default:       o = '0;
        endcase
        return o;
    endfunction

    // Feedback mask: bit i set means q[i] is XORed into the new LSB.
    function automatic word_t lfsr_taps(input int w);
        word_t t;
        case (w)
            2:       t = 16'h0003;
            3:       t = 16'h0006;
            4:       t = 16'h000C;
            5:       t = 16'h0014;
            6:       t = 16'h0030;
            7:       t = 16'h0060;
            8:       t = 16'h00B8;
            9:       t = 16'h0110;
            10:      t = 16'h0240;
            11:      t = 16'h0500;
            12:      t = 16'h0829;
            13:      t = 16'h100D;
            14:      t = 16'h2015;
            15:      t = 16'h6000;
            16:      t = 16'hD008;
            default: t = '0;
        endcase
        return t;
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/seq_reg.sv
// State register for seq_gen: holds {wrap, q} with a synchronous active-high reset.
module seq_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Multi-mode sequence generator (binary up/down, Gray, Johnson, LFSR) with
// load, origin-wrap pulse and a combinational match flag.
module seq_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] match_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             y
);
    import seq_gen_pkg::*;

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("seq_gen: WIDTH=%0d outside legal range 2..16", WIDTH);
    end

    localparam word_t MASK   = width_mask(WIDTH);
    localparam word_t TAPS_W = lfsr_taps(WIDTH);
    localparam word_t ONE    = word_t'(1);

    // Returns {wrap, next q} for one en step of the given mode from cur.
    function automatic logic [WIDTH:0] next_step(input logic [2:0] m,
                                                 input logic [WIDTH-1:0] cur);
        word_t wide;
        word_t nxt;
        word_t org;
        logic  escape;
        logic  legal;
        wide   = word_t'(cur);
        nxt    = wide;
        escape = 1'b0;
        legal  = 1'b1;
        case (m)
            MODE_BIN_UP:   nxt = wide + ONE;
            MODE_BIN_DOWN: nxt = wide - ONE;
            MODE_GRAY:     nxt = bin2gray((gray2bin(wide) + ONE) & MASK);
            MODE_JOHNSON:  nxt = word_t'({cur[WIDTH-2:0], ~cur[WIDTH-1]});
            MODE_LFSR: begin
                // All-zero is the LFSR lock-up state; kick it to the origin silently.
                if (cur == '0) begin
                    nxt    = ONE;
                    escape = 1'b1;
                end else begin
                    nxt = word_t'({cur[WIDTH-2:0], ^(cur & TAPS_W[WIDTH-1:0])});
                end
            end
            default:       legal = 1'b0;
        endcase
        nxt = nxt & MASK;
        org = origin_val(seq_mode_t'(m), WIDTH);
        return {legal && !escape && (nxt == org), nxt[WIDTH-1:0]};
    endfunction

    logic [WIDTH:0] state;
    logic [WIDTH:0] step;
    logic [WIDTH:0] d;

    always_comb begin
        step = next_step(mode, state[WIDTH-1:0]);
        if (load) begin
            d = {1'b0, load_val};
        end else if (en) begin
            d = step;
        end else begin
            d = {1'b0, state[WIDTH-1:0]};
        end
    end

    seq_reg #(
        .WIDTH(WIDTH + 1)
    ) u_seq_reg (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (state)
    );

    assign q    = state[WIDTH-1:0];
    assign wrap = state[WIDTH];
    assign y    = (q == match_val);

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen (WIDTH=4): directed vector table, combinational
// match checks and a randomized run against a behavioural sequence model.
module tb_seq_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         load;
    logic [2:0]   mode;
    logic [W-1:0] load_val;
    logic [W-1:0] match_val;
    logic [W-1:0] q;
    logic         wrap;
    logic         y;

    seq_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load      (load),
        .mode      (mode),
        .load_val  (load_val),
        .match_val (match_val),
        .q         (q),
        .wrap      (wrap),
        .y         (y)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       r;
        logic       l;
        logic       e;
        logic [2:0] m;
        logic [3:0] lv;
        logic [3:0] mv;
        logic [3:0] eq;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic l, input logic e, input logic [2:0] m,
                       input logic [3:0] lv, input logic [3:0] mv,
                       input logic [3:0] eq, input logic ew);
        vec_t v;
        v.r = r; v.l = l; v.e = e; v.m = m;
        v.lv = lv; v.mv = mv; v.eq = eq; v.ew = ew;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic [2:0] m,
                         input logic [3:0] lv, input logic [3:0] mv);
        reset = r; load = l; en = e; mode = m; load_val = lv; match_val = mv;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: sequences described by their mathematical rules.
    function automatic int gray_next(input int g);
        int idx;
        int n;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if ((i ^ (i >> 1)) == g) idx = i;
        end
        n = (idx + 1) % 16;
        return n ^ (n >> 1);
    endfunction

    function automatic int model_next(input int m, input int cur);
        case (m)
            0: return (cur + 1) % 16;
            1: return (cur + 15) % 16;
            2: return gray_next(cur);
            3: return ((cur * 2) % 16) + (1 - ((cur / 8) % 2));
            4: return (cur == 0) ? 1 : ((cur * 2) % 16) + (((cur / 8) + (cur / 4)) % 2);
            default: return cur;
        endcase
    endfunction

    function automatic int model_wrap(input int m, input int cur, input int nxt);
        int origins[5] = '{0, 15, 0, 0, 1};
        if (m > 4) return 0;
        if (m == 4 && cur == 0) return 0;
        return (nxt == origins[m]) ? 1 : 0;
    endfunction

    initial begin
        logic [3:0] gray_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                      4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        logic [3:0] john_seq [8]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        logic [3:0] lfsr_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                      4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        logic [3:0] prev_q;
        int mq;
        int exp_q;
        int exp_w;
        int cur_mode;

        // Reset (y=1 since match_val=0), then a full binary-up lap.
        add(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
        add(1, 0, 1, 2, 4'h0, 4'h3, 4'h0, 0);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 0, 4'h0, 4'h9, 4'(i), i == 16);
        add(0, 0, 0, 0, 4'h0, 4'h9, 4'h0, 0);
        // Binary down from reset wraps immediately to all-ones.
        add(1, 0, 0, 1, 4'h0, 4'hF, 4'h0, 0);
        add(0, 0, 1, 1, 4'h0, 4'hF, 4'hF, 1);
        add(0, 0, 1, 1, 4'h0, 4'hF, 4'hE, 0);
        add(0, 0, 1, 1, 4'h0, 4'hF, 4'hD, 0);
        add(1, 0, 0, 2, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 16; i++) add(0, 0, 1, 2, 4'h0, 4'h0, gray_seq[i], i == 15);
        add(1, 0, 0, 3, 4'h0, 4'h0, 4'h0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 3, 4'h0, 4'h0, john_seq[i], i == 7);
        // LFSR lock-up escape: 0 -> 1 without wrap, then the 15-state cycle.
        add(0, 1, 0, 4, 4'h0, 4'h1, 4'h0, 0);
        add(0, 0, 1, 4, 4'h0, 4'h1, 4'h1, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 1, 4, 4'h0, 4'h1, lfsr_seq[i], i == 14);
        // Load beats en; reserved modes hold; load never wraps.
        add(0, 1, 1, 0, 4'h5, 4'h5, 4'h5, 0);
        add(0, 0, 1, 6, 4'h0, 4'h5, 4'h5, 0);
        add(0, 0, 1, 7, 4'h0, 4'h2, 4'h5, 0);
        add(0, 1, 0, 1, 4'hF, 4'h2, 4'hF, 0);
        add(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 1);
        add(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0);
        // Reset mid-sequence at q=7 overrides load and en.
        add(0, 1, 0, 0, 4'h6, 4'h7, 4'h6, 0);
        add(0, 0, 1, 0, 4'h0, 4'h7, 4'h7, 0);
        add(1, 1, 1, 0, 4'h3, 4'h7, 4'h0, 0);
        add(0, 0, 1, 0, 4'h0, 4'h1, 4'h1, 0);

        prev_q = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].m, vecs[i].lv, vecs[i].mv);
            check($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].eq));
            check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].ew));
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].eq == vecs[i].mv));
            if (vecs[i].m == 3'd2 && vecs[i].e && !vecs[i].l && !vecs[i].r) begin
                check($sformatf("vec%0d_gray_hamming", i), 32'($countones(q ^ prev_q)), 32'd1);
            end
            prev_q = q;
        end

        // y responds to match_val with no clock edge; q is known to be 1 here.
        en = 1'b0; load = 1'b0;
        match_val = 4'h1; #1;
        check("y_comb_hit", 32'(y), 32'd1);
        match_val = 4'hE; #1;
        check("y_comb_miss", 32'(y), 32'd0);

        // Randomized run against the reference model.
        mq = 1;
        cur_mode = 0;
        for (int i = 0; i < 600; i++) begin
            logic r_r;
            logic r_l;
            logic r_e;
            logic [3:0] r_lv;
            logic [3:0] r_mv;
            r_r  = ($urandom_range(0, 31) == 0);
            r_l  = ($urandom_range(0, 9) == 0);
            r_e  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) cur_mode = $urandom_range(0, 7);
            r_lv = 4'($urandom_range(0, 15));
            r_mv = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'(model_next(cur_mode, mq));
            if (r_r) begin
                exp_q = 0; exp_w = 0;
            end else if (r_l) begin
                exp_q = int'(r_lv); exp_w = 0;
            end else if (r_e) begin
                exp_q = model_next(cur_mode, mq);
                exp_w = model_wrap(cur_mode, mq, exp_q);
            end else begin
                exp_q = mq; exp_w = 0;
            end
            drive(r_r, r_l, r_e, 3'(cur_mode), r_lv, r_mv);
            check($sformatf("rnd%0d_q", i), 32'(q), 32'(exp_q));
            check($sformatf("rnd%0d_wrap", i), 32'(wrap), 32'(exp_w));
            check($sformatf("rnd%0d_y", i), 32'(y), 32'(exp_q == int'(r_mv)));
            mq = exp_q;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The parameters SHALL be:
- WIDTH, default 4: state width; legal range 2..16.
REQ-002 The ports SHALL be (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance the sequence one step.
- load  input  1  load load_val into the state.
- mode  input  3  sequence select.
- load_val  input  WIDTH  value loaded when load=1.
- match_val  input  WIDTH  compare value for y.
- q  output  WIDTH  current state, registered.
- wrap  output  1  registered one-cycle pulse on return to the origin value.
- y  output  1  combinational, q == match_val.
REQ-003 The design SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Priority at each rising edge SHALL be reset > load > en > hold.
REQ-005 On load=1, q SHALL take load_val on the next edge, in any mode including reserved modes, and wrap SHALL be 0.
REQ-006 With en=0 and load=0, q SHALL hold and wrap SHALL be 0.
REQ-007 The mode encodings SHALL be 0 BIN_UP, 1 BIN_DOWN, 2 GRAY, 3 JOHNSON, 4 LFSR, 5..7 reserved.
REQ-008 In reserved modes, an en step SHALL hold q and drive wrap=0.
REQ-009 BIN_UP step: q <= q+1, modulo 2^WIDTH.
REQ-010 BIN_DOWN step: q <= q-1, modulo 2^WIDTH.
REQ-011 GRAY step: q <= bin2gray(gray2bin(q)+1), modulo 2^WIDTH, so exactly one bit changes per step.
REQ-012 JOHNSON step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}; period 2*WIDTH from 0.
REQ-013 LFSR step: Fibonacci shift left, with the new LSB equal to the XOR of the tap bits of q. Taps come from the package table, maximal length for each WIDTH (WIDTH=4: q[3]^q[2]); period 2^WIDTH-1.
REQ-014 In LFSR mode, an en step from q=0 SHALL produce q=1 (lock-up escape), and wrap SHALL be 0 on that step.
REQ-015 Origin values SHALL be:
- BIN_UP 0; BIN_DOWN all-ones; GRAY 0; JOHNSON 0; LFSR 1.
REQ-016 wrap SHALL be 1 for exactly the cycle following an en step that moves q to the origin value of the current mode; load and reset SHALL never set wrap.
REQ-017 A mode change SHALL take effect on the next edge; the next step SHALL be computed from the current q under the new mode, with no flush.
REQ-018 Johnson-mode steps from a non-Johnson value SHALL follow REQ-012 as written, with no correction.
REQ-019 y SHALL equal (q == match_val) combinationally, with zero latency from q or match_val.
REQ-020 Step latency SHALL be one clock: q reflects the step on the edge where en is sampled.

Reset
REQ-021 reset=1 at an edge SHALL set q=0 and wrap=0, regardless of en, load and mode.
REQ-022 A reset asserted mid-sequence SHALL abandon the sequence; after reset releases, the first en step SHALL start from q=0.
REQ-023 During reset, y SHALL follow REQ-019, i.e. y=1 iff match_val=0.

Structure
REQ-024 Package seq_gen_pkg SHALL hold:
- the mode enum (seq_mode_t);
- origin-value function;
- LFSR tap table for WIDTH 2..16;
- bin2gray and gray2bin functions.
REQ-025 The next-state logic SHALL be a single combinational function of (mode, q). All state (q, wrap) SHALL be held in one sub-module, seq_reg: a WIDTH+1-bit register with synchronous active-high reset, instantiated once.
REQ-026 Illegal WIDTH values SHALL raise an elaboration-time error.

Verification (WIDTH=4)
REQ-027 Scenario: reset, then BIN_UP with en=1 for 16 edges -> q = 1..15, 0; wrap=1 only in the cycle after q returns to 0; y=1 only while q == match_val (=9).
REQ-028 Scenario: reset, then BIN_DOWN with en=1 -> first step gives q=F with wrap=1; then E, D, ...
REQ-029 Scenario: reset, then GRAY for 16 steps -> q = 1, 3, 2, 6, 7, 5, 4, C, D, F, E, A, B, 9, 8, 0; wrap on the final step; Hamming distance 1 on every step.
REQ-030 Scenario: reset, then JOHNSON -> q = 1, 3, 7, F, E, C, 8, 0; wrap on the step to 0; period 8.
REQ-031 Scenario: LFSR, load 0, then en -> q=1 with wrap=0; then 2, 4, 9, 3, 6, D, A, 5, B, 7, F, E, C, 8, 1 with wrap=1 on the return to 1.
REQ-032 Scenario: load=1 and en=1 together with load_val=5 -> q=5, wrap=0; mode=6 with en -> q holds; reset pulse at q=7 in BIN_UP -> q=0, and the next step gives 1.
